// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter shared by instruction fetch and the data-memory stage.
// Reads are assembled little-endian into 32 bits; stores are written one byte per cycle.
module mem_ctrl #(
    parameter int ADDR_W        = 32,
    parameter bit IDLE_PRIO_MEM = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic [31:0]       if_data_q, if_data_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              mem_done_q, mem_done_d;
    logic              grant_mem;
    logic [1:0]        byte_idx;

    // Byte captured this cycle belongs to the address issued two cycles earlier.
    assign byte_idx = cnt_q[1:0] - 2'd2;

    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            2'd0:    len_to_bytes = 3'd1;
            2'd1:    len_to_bytes = 3'd2;
            default: len_to_bytes = 3'd4;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_data_d   = if_data_q;
        if_done_d   = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_done_d  = 1'b0;
        grant_mem   = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle still sees the finished requester's req high, so skip it.
                if (!if_done_q && !mem_done_q) begin
                    grant_mem = mem_req_i && (IDLE_PRIO_MEM || !if_req_i);
                    if (grant_mem) begin
                        base_d     = mem_addr_i;
                        nbytes_d   = len_to_bytes(mem_len_i);
                        wdata_d    = mem_wdata_i;
                        cnt_d      = 3'd1;
                        ram_addr_d = mem_addr_i;
                        rbuf_d     = 32'd0;
                        if (mem_we_i) begin
                            state_d    = STORE;
                            ram_we_d   = 1'b1;
                            ram_dout_d = mem_wdata_i[7:0];
                        end else begin
                            state_d = LOAD;
                        end
                    end else if (if_req_i) begin
                        base_d     = if_addr_i;
                        nbytes_d   = 3'd4;
                        cnt_d      = 3'd1;
                        ram_addr_d = if_addr_i;
                        rbuf_d     = 32'd0;
                        state_d    = FETCH;
                    end
                end
            end

            FETCH, LOAD: begin
                if (state_q == FETCH && !if_req_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < nbytes_q) begin
                        ram_addr_d = base_q + ADDR_W'(cnt_q);
                    end
                    if (cnt_q >= 3'd2) begin
                        rbuf_d[{byte_idx, 3'b000} +: 8] = ram_din_i;
                    end
                    if (cnt_q == nbytes_q + 3'd1) begin
                        state_d = IDLE;
                        if (state_q == FETCH) begin
                            if_data_d = rbuf_d;
                            if_done_d = 1'b1;
                        end else begin
                            mem_rdata_d = rbuf_d;
                            mem_done_d  = 1'b1;
                        end
                    end
                end
            end

            STORE: begin
                if (cnt_q == nbytes_q) begin
                    state_d    = IDLE;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    ram_addr_d = base_q + ADDR_W'(cnt_q);
                    ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    ram_we_d   = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            nbytes_q    <= 3'd0;
            base_q      <= '0;
            wdata_q     <= 32'd0;
            rbuf_q      <= 32'd0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
            if_data_q   <= 32'd0;
            if_done_q   <= 1'b0;
            mem_rdata_q <= 32'd0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_dout_q  <= ram_dout_d;
            if_data_q   <= if_data_d;
            if_done_q   <= if_done_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign if_data_o   = if_data_q;
    assign if_done_o   = if_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_done_o  = mem_done_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_we_o    = ram_we_q;
    assign ram_dout_o  = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a behavioural byte RAM, a table of load/store vectors
// and hand-written sequences for arbitration, fetch abort, reset mid-store and wrap.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic [31:0] ram_addr_o;
    logic        ram_we_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din;

    int checks = 0;
    int errors = 0;

    logic [31:0] trAddr [0:31];
    logic        trWe   [0:31];
    logic [7:0]  trDout [0:31];
    bit          sawOtherDone;

    typedef struct {
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        int          expLat;
    } vec_t;

    vec_t vecs [0:7];

    mem_ctrl #(.ADDR_W(32), .IDLE_PRIO_MEM(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_data_o  (if_data_o),
        .if_done_o  (if_done_o),
        .mem_req_i  (mem_req),
        .mem_we_i   (mem_we),
        .mem_len_i  (mem_len),
        .mem_addr_i (mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata_o),
        .mem_done_o (mem_done_o),
        .ram_addr_o (ram_addr_o),
        .ram_we_o   (ram_we_o),
        .ram_dout_o (ram_dout_o),
        .ram_din_i  (ram_din)
    );

    always #5 clk = ~clk;

    // Synchronous-read byte RAM, 4 KiB aliased over the address space.
    logic [7:0] ram [0:4095];
    always @(posedge clk) begin
        if (ram_we_o) ram[ram_addr_o[11:0]] <= ram_dout_o;
        ram_din <= ram[ram_addr_o[11:0]];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction; cycle 0 is the first cycle after entry. doneCyc = -1 on timeout.
    task automatic applyStimulus(input bit isIf, input bit we, input logic [1:0] len,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int doneCyc, output logic [31:0] data);
        tick();
        if (isIf) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_len   = len;
            mem_addr  = addr;
            mem_wdata = wdata;
        end
        doneCyc      = -1;
        data         = 32'd0;
        sawOtherDone = 1'b0;
        for (int c = 1; c <= 20 && doneCyc < 0; c++) begin
            tick();
            if (c == 1 && !isIf) begin
                mem_addr  = ~addr;
                mem_wdata = ~wdata;
                mem_we    = ~we;
                mem_len   = 2'd0;
            end
            trAddr[c] = ram_addr_o;
            trWe[c]   = ram_we_o;
            trDout[c] = ram_dout_o;
            if (isIf ? if_done_o : mem_done_o) begin
                doneCyc = c;
                data    = isIf ? if_data_o : mem_rdata_o;
            end
            if (isIf ? mem_done_o : if_done_o) sawOtherDone = 1'b1;
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
    endtask

    initial begin
        int          lat;
        int          memDone;
        int          ifDone;
        logic [31:0] rd;
        logic [31:0] memData;
        logic [31:0] ifData;
        bit          sawIf;
        bit          sawMem;

        vecs[0] = '{1'b0, 2'd3, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 6};
        vecs[1] = '{1'b0, 2'd0, 32'h0000_0103, 32'h0,         32'h0000_00DE, 3};
        vecs[2] = '{1'b0, 2'd1, 32'h0000_0102, 32'h0,         32'h0000_DEAD, 4};
        vecs[3] = '{1'b1, 2'd1, 32'h0000_0200, 32'hAAAA_1234, 32'h0,         3};
        vecs[4] = '{1'b0, 2'd3, 32'h0000_0200, 32'h0,         32'h0000_1234, 6};
        vecs[5] = '{1'b1, 2'd0, 32'h0000_0204, 32'h5566_7788, 32'h0,         2};
        vecs[6] = '{1'b0, 2'd2, 32'h0000_0203, 32'h0,         32'h0000_8800, 6};
        vecs[7] = '{1'b0, 2'd0, 32'h0000_0204, 32'h0,         32'h0000_0088, 3};

        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h010] = 8'h13;
        ram[12'h011] = 8'h00;
        ram[12'h012] = 8'h50;
        ram[12'h013] = 8'h00;
        ram[12'hFFF] = 8'h34;
        ram[12'h000] = 8'h12;

        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("reset ram_addr", ram_addr_o, 32'h0);
        checkOutput("reset ram_we", {31'd0, ram_we_o}, 32'h0);
        checkOutput("reset dones", {30'd0, if_done_o, mem_done_o}, 32'h0);
        checkOutput("reset if_data", if_data_o, 32'h0);
        checkOutput("reset mem_rdata", mem_rdata_o, 32'h0);

        // Instruction fetch of a word at 0x10.
        applyStimulus(1'b1, 1'b0, 2'd3, 32'h10, 32'h0, lat, rd);
        checkOutput("fetch latency", lat, 32'd6);
        checkOutput("fetch data", rd, 32'h0050_0013);
        checkOutput("fetch no mem_done", {31'd0, sawOtherDone}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("fetch addr c%0d", k + 1), trAddr[k + 1], 32'h10 + k);
            checkOutput($sformatf("fetch we c%0d", k + 1), {31'd0, trWe[k + 1]}, 32'h0);
        end

        // Word store of 0xDEADBEEF at 0x100.
        applyStimulus(1'b0, 1'b1, 2'd3, 32'h100, 32'hDEAD_BEEF, lat, rd);
        checkOutput("store latency", lat, 32'd5);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] wv;
            wv = 32'hDEAD_BEEF;
            checkOutput($sformatf("store we c%0d", k + 1), {31'd0, trWe[k + 1]}, 32'h1);
            checkOutput($sformatf("store addr c%0d", k + 1), trAddr[k + 1], 32'h100 + k);
            checkOutput($sformatf("store dout c%0d", k + 1), {24'd0, trDout[k + 1]}, {24'd0, wv[8*k +: 8]});
        end
        checkOutput("store we at done", {31'd0, trWe[5]}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata, lat, rd);
            checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
            if (!vecs[i].we) checkOutput($sformatf("vec%0d data", i), rd, vecs[i].expData);
        end

        // Simultaneous requests: MEM wins, IF follows straight after.
        tick();
        if_req = 1'b1; if_addr = 32'h10;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd3; mem_addr = 32'h100;
        memDone = -1; ifDone = -1; memData = 32'h0; ifData = 32'h0;
        for (int c = 1; c <= 20 && ifDone < 0; c++) begin
            tick();
            trAddr[c] = ram_addr_o;
            if (mem_done_o && memDone < 0) begin
                memDone = c; memData = mem_rdata_o; mem_req = 1'b0;
            end
            if (if_done_o) begin
                ifDone = c; ifData = if_data_o;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        checkOutput("prio mem done", memDone, 32'd6);
        checkOutput("prio mem data", memData, 32'hDEAD_BEEF);
        checkOutput("prio if done", ifDone, 32'd13);
        checkOutput("prio if data", ifData, 32'h0050_0013);
        checkOutput("prio addr c4", trAddr[4], 32'h103);
        checkOutput("prio addr c8", trAddr[8], 32'h10);
        checkOutput("prio addr c11", trAddr[11], 32'h13);

        // Fetch abandoned in cycle 2, load issued in cycle 3.
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        sawIf = 1'b0; memDone = -1; memData = 32'h0;
        tick();
        if (if_done_o) sawIf = 1'b1;
        tick();
        if (if_done_o) sawIf = 1'b1;
        if_req = 1'b0;
        tick();
        if (if_done_o) sawIf = 1'b1;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h103;
        for (int c = 4; c <= 20 && memDone < 0; c++) begin
            tick();
            trAddr[c] = ram_addr_o;
            if (if_done_o) sawIf = 1'b1;
            if (mem_done_o) begin
                memDone = c; memData = mem_rdata_o;
            end
        end
        mem_req = 1'b0;
        checkOutput("abort no if_done", {31'd0, sawIf}, 32'h0);
        checkOutput("abort if_data held", if_data_o, 32'h0050_0013);
        checkOutput("abort load addr c4", trAddr[4], 32'h103);
        checkOutput("abort load done", memDone, 32'd6);
        checkOutput("abort load data", memData, 32'h0000_00DE);

        // Reset asserted in cycle 2 of a word store.
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h300; mem_wdata = 32'hCAFE_F00D;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_req = 1'b0;
        checkOutput("rst ram_we c3", {31'd0, ram_we_o}, 32'h0);
        checkOutput("rst ram_addr", ram_addr_o, 32'h0);
        checkOutput("rst ram_dout", {24'd0, ram_dout_o}, 32'h0);
        checkOutput("rst mem_rdata", mem_rdata_o, 32'h0);
        checkOutput("rst if_data", if_data_o, 32'h0);
        sawMem = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (mem_done_o || if_done_o || ram_we_o) sawMem = 1'b1;
            tick();
        end
        checkOutput("rst no done/write", {31'd0, sawMem}, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'd3, 32'h300, 32'h0, lat, rd);
        checkOutput("rst partial latency", lat, 32'd6);
        checkOutput("rst partial data", rd, 32'h0000_F00D);

        // Half load straddling the top of the address space.
        applyStimulus(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, lat, rd);
        checkOutput("wrap latency", lat, 32'd4);
        checkOutput("wrap addr c1", trAddr[1], 32'hFFFF_FFFF);
        checkOutput("wrap addr c2", trAddr[2], 32'h0000_0000);
        checkOutput("wrap data", rd, 32'h0000_1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
